// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the fifo block and its write-side arbiter.
//   FIFO_WIDTH  - default data width, common to fifo and fifo_wr_arbiter
//   arb_state_t - write arbiter FSM states (IDLE, GRANT)
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority search.
// Scans vec upward starting at bit 'start', wrapping modulo N, and reports
// the first set bit.
//   vec   in  N   - candidate bits
//   start in  IW  - index to search from (must be < N)
//   hit   out 1   - at least one bit of vec is set
//   idx   out IW  - index of the first set bit at or after start (0 if no hit)
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] start,
    output logic          hit,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] pos;

    always_comb begin
        hit = 1'b0;
        idx = '0;
        pos = '0;
        for (int unsigned off = 0; off < N; off++) begin
            pos = IW'((32'(start) + off) % N);
            if (!hit && vec[pos]) begin
                hit = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the fifo write port between
// N_REQ valid/ready requesters, granting bursts of up to BURST beats.
//   clk        in  1           - rising-edge clock
//   reset      in  1           - synchronous, active-high reset
//   req_valid  in  N_REQ       - requester i has a word on its data slice
//   req_data   in  N_REQ*WIDTH - requester i data at [i*WIDTH +: WIDTH]
//   req_ready  out N_REQ       - one-hot or zero; accept when valid & ready
//   fifo_full  in  1           - back-pressure from fifo
//   w_valid    out 1           - write strobe to fifo
//   data_in    out WIDTH       - write data to fifo
//   grant_id   out clog2(N_REQ)- current/last granted requester
//   busy       out 1           - high while a grant is held
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       fifo_full,
    output logic                       w_valid,
    output logic [WIDTH-1:0]           data_in,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(BURST + 1);

    arb_state_t    state, state_next;
    logic [IW-1:0] rr_ptr, rr_next;
    logic [IW-1:0] grant_next;
    logic [CW-1:0] beat_cnt, cnt_next;

    logic          pick_hit;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] g_succ;
    logic          g_valid;
    logic          last_beat;
    logic [WIDTH-1:0] slice [N_REQ];

    rr_pick #(.N(N_REQ)) u_pick (
        .vec   (req_valid),
        .start (rr_ptr),
        .hit   (pick_hit),
        .idx   (pick_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            slice[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Data mux follows the grant even in IDLE; it is only qualified by w_valid.
    assign data_in   = slice[grant_id];
    assign g_valid   = req_valid[grant_id];
    assign last_beat = (beat_cnt == CW'(BURST - 1));
    assign g_succ    = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy      = (state == GRANT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_next;
            grant_id <= grant_next;
            beat_cnt <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        rr_next    = rr_ptr;
        grant_next = grant_id;
        cnt_next   = beat_cnt;
        req_ready  = '0;
        w_valid    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_hit) begin
                    grant_next = pick_idx;
                    cnt_next   = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                req_ready[grant_id] = ~fifo_full;
                w_valid             = g_valid & ~fifo_full;
                // While full nothing moves: counter frozen, grant held, and
                // the idle-release check is suppressed.
                if (w_valid) begin
                    cnt_next = beat_cnt + 1'b1;
                    if (last_beat) begin
                        state_next = IDLE;
                        rr_next    = g_succ;
                    end
                end else if (!g_valid && !fifo_full) begin
                    state_next = IDLE;
                    rr_next    = g_succ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: self-checking bench for fifo_wr_arbiter.
// Directed vector table, hand-written burst/back-pressure sequences and a
// randomized run checked against a behavioural grant model.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           w_valid;
    logic [W-1:0]   data_in;
    logic [1:0]     grant_id;
    logic           busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .BURST(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .w_valid   (w_valid),
        .data_in   (data_in),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Per-requester pending words; head is what the requester presents.
    logic [W-1:0] src [N][$];

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
        int           gid;
    } wr_t;
    wr_t wr_log[$];

    // Behavioural model: owner -1 means no grant held.
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    int m_gid   = 0;

    logic           cur_rst, cur_full;
    logic           e_wv;
    logic [N-1:0]   e_rdy;
    logic           s_wv;
    logic [W-1:0]   s_data;
    int             s_gid;
    logic [N-1:0]   acc;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       full;
        logic       wv;
        logic [3:0] rdy;
        logic       busy;
        logic [1:0] gid;
        int         ptr;
        int         cnt;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic full,
                                input logic wv, input logic [3:0] rdy, input logic bsy,
                                input logic [1:0] gid, input int ptr, input int cnt);
        vec_t t;
        t.rst = rst; t.v = v; t.full = full; t.wv = wv; t.rdy = rdy;
        t.busy = bsy; t.gid = gid; t.ptr = ptr; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive inputs (called just after a falling edge), then check outputs.
    task automatic apply(input logic rst, input logic full, input logic [N-1:0] gate);
        logic         e_busy;
        logic [W-1:0] e_data;
        cur_rst   = rst;
        cur_full  = full;
        reset     = rst;
        fifo_full = full;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = gate[i] && (src[i].size() > 0);
            req_data[i*W +: W] = (src[i].size() > 0) ? src[i][0] : '0;
        end
        #1;
        e_busy = (m_owner >= 0);
        e_rdy  = '0;
        e_wv   = 1'b0;
        e_data = '0;
        if (m_owner >= 0) begin
            e_rdy[m_owner] = !full;
            e_wv           = req_valid[m_owner] && !full;
            if (e_wv) e_data = src[m_owner][0];
        end
        if (chk_en) begin
            chk("model.busy",      64'(busy),      64'(e_busy));
            chk("model.grant_id",  64'(grant_id),  64'(m_gid));
            chk("model.w_valid",   64'(w_valid),   64'(e_wv));
            chk("model.req_ready", 64'(req_ready), 64'(e_rdy));
            if (e_wv) chk("model.data_in", 64'(data_in), 64'(e_data));
        end
        s_wv   = w_valid;
        s_data = data_in;
        s_gid  = int'(grant_id);
        acc    = req_valid & req_ready;
    endtask

    // Advance one rising edge: log writes, retire accepted words, step model.
    task automatic clock_edge();
        @(posedge clk);
        if (!cur_rst && s_wv) wr_log.push_back('{s_data, cyc, s_gid});
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(src[i].pop_front());
        end
        if (cur_rst) begin
            m_owner = -1; m_beats = 0; m_ptr = 0; m_gid = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                automatic int c = (m_ptr + k) % N;
                if (req_valid[c]) begin
                    m_owner = c; m_gid = c; m_beats = 0;
                    break;
                end
            end
        end else if (e_wv) begin
            m_beats++;
            if (m_beats == B) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1;
            end
        end else if (!req_valid[m_owner] && !cur_full) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) src[i].delete();
        apply(1'b1, 1'b0, '0); clock_edge();
        apply(1'b1, 1'b0, '0); clock_edge();
        wr_log.delete();
    endtask

    initial begin
        int t0;
        int nw;
        logic [N-1:0] pend;
        logic [N-1:0] gate;
        logic rst, full;
        int bp_cyc[4];

        reset = 1'b1; fifo_full = 1'b0; req_valid = '0; req_data = '0;

        //                rst  v        full wv   rdy      busy gid    ptr cnt
        tbl[0]  = mk(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0,  0, 0);
        tbl[1]  = mk(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0,  0, 0);
        tbl[2]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0,  0, -1);
        tbl[3]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, -1, -1);
        tbl[4]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, -1, -1);
        tbl[5]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, -1, -1);
        tbl[6]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0,  0, -1);
        tbl[7]  = mk(1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, -1, -1);
        tbl[8]  = mk(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, -1, 0);
        tbl[9]  = mk(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, -1, 1);
        tbl[10] = mk(1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, -1, 2);
        tbl[11] = mk(1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, -1, 2);
        tbl[12] = mk(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, -1, 2);
        tbl[13] = mk(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, -1, 3);
        tbl[14] = mk(1'b0, 4'b1100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2,  3, -1);
        tbl[15] = mk(1'b0, 4'b1100, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, -1, 0);
        tbl[16] = mk(1'b0, 4'b0101, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, -1, 1);
        tbl[17] = mk(1'b0, 4'b0101, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3,  0, -1);
        tbl[18] = mk(1'b0, 4'b0101, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, -1, 0);
        tbl[19] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, -1, 1);
        tbl[20] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, -1, 1);
        tbl[21] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0,  1, -1);
        tbl[22] = mk(1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0,  1, -1);
        tbl[23] = mk(1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, -1, 0);
        tbl[24] = mk(1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, -1, 1);
        tbl[25] = mk(1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0,  0, 0);
        tbl[26] = mk(1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, -1, 0);

        // Power-up: one unchecked reset edge so state is defined.
        apply(1'b1, 1'b0, '0);
        clock_edge();
        chk_en = 1'b1;

        // ---- Directed vector table ----
        for (int i = 0; i < N; i++) begin
            for (int b = 0; b < 40; b++) src[i].push_back(32'(32'h100 + i));
        end
        for (int r = 0; r < 27; r++) begin
            apply(tbl[r].rst, tbl[r].full, tbl[r].v);
            chk($sformatf("tbl[%0d].w_valid", r),   64'(w_valid),   64'(tbl[r].wv));
            chk($sformatf("tbl[%0d].req_ready", r), 64'(req_ready), 64'(tbl[r].rdy));
            chk($sformatf("tbl[%0d].busy", r),      64'(busy),      64'(tbl[r].busy));
            chk($sformatf("tbl[%0d].grant_id", r),  64'(grant_id),  64'(tbl[r].gid));
            if (tbl[r].wv)
                chk($sformatf("tbl[%0d].data_in", r), 64'(data_in), 64'(32'h100 + 32'(tbl[r].gid)));
            if (tbl[r].ptr >= 0)
                chk($sformatf("tbl[%0d].rr_ptr", r), 64'(dut.rr_ptr), 64'(tbl[r].ptr));
            if (tbl[r].cnt >= 0)
                chk($sformatf("tbl[%0d].beat_cnt", r), 64'(dut.beat_cnt), 64'(tbl[r].cnt));
            clock_edge();
        end

        // ---- Single requester, 10 words in bursts of 4 ----
        do_reset();
        for (int k = 0; k < 10; k++) src[2].push_back(32'(32'h20 + k));
        t0 = cyc;
        for (int c = 0; c < 16; c++) begin
            apply(1'b0, 1'b0, '1);
            clock_edge();
        end
        chk("single.count", 64'(wr_log.size()), 64'd10);
        for (int k = 0; k < 10 && k < wr_log.size(); k++) begin
            chk($sformatf("single[%0d].data", k), 64'(wr_log[k].data), 64'(32'h20 + k));
            chk($sformatf("single[%0d].cycle", k), 64'(wr_log[k].cyc - t0), 64'(1 + k + k / 4));
            chk($sformatf("single[%0d].gid", k), 64'(wr_log[k].gid), 64'd2);
        end

        // ---- Round-robin, all four valid with tagged data ----
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int b = 0; b < 8; b++) src[i].push_back(32'(32'hA0 + i * 16 + b));
        end
        nw = 0;
        while (wr_log.size() < 32 && nw < 60) begin
            apply(1'b0, 1'b0, '1);
            clock_edge();
            nw++;
        end
        chk("rr.count", 64'(wr_log.size()), 64'd32);
        for (int k = 0; k < 32 && k < wr_log.size(); k++) begin
            automatic int grp  = k / 4;
            automatic int rq   = grp % 4;
            automatic int beat = (grp / 4) * 4 + k % 4;
            chk($sformatf("rr[%0d].data", k), 64'(wr_log[k].data), 64'(32'hA0 + rq * 16 + beat));
            chk($sformatf("rr[%0d].gid", k), 64'(wr_log[k].gid), 64'(rq));
        end

        // ---- Back-pressure on beat 2 of requester 1 ----
        do_reset();
        for (int k = 0; k < 4; k++) src[1].push_back(32'(32'h50 + k));
        t0 = cyc;
        for (int c = 0; c < 12; c++) begin
            full = (c >= 3 && c <= 5);
            apply(1'b0, full, '1);
            if (full) chk($sformatf("bp.beat_cnt@%0d", c), 64'(dut.beat_cnt), 64'd2);
            clock_edge();
        end
        bp_cyc = '{1, 2, 6, 7};
        chk("bp.count", 64'(wr_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
            chk($sformatf("bp[%0d].data", k), 64'(wr_log[k].data), 64'(32'h50 + k));
            chk($sformatf("bp[%0d].cycle", k), 64'(wr_log[k].cyc - t0), 64'(bp_cyc[k]));
        end

        // ---- Randomized run against the model ----
        do_reset();
        pend = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src[i].size() < 2) src[i].push_back($urandom);
                gate[i] = pend[i] ? 1'b1 : ($urandom_range(0, 2) != 0);
            end
            rst  = ($urandom_range(0, 199) == 0);
            full = ($urandom_range(0, 3) == 0);
            apply(rst, full, gate);
            clock_edge();
            pend = rst ? '0 : (req_valid & ~acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the `fifo` block between `N_REQ` requesters. Each requester gets a valid/ready handshake. The arbiter grants one requester at a time for a burst of up to `BURST` beats. While granted, it drives `w_valid`/`data_in` onto the FIFO and respects `fifo_full` back-pressure. It sits directly in front of `fifo`, replacing a single-source write driver.

## Interface
- `N_REQ`, 4: number of requesters; ≥2.
- `WIDTH`, 32: data width; matches the `fifo` `WIDTH`.
- `BURST`, 4: maximum beats per grant; ≥1.
- `clk` in 1: clock; all logic is rising-edge.
- `reset` in 1: reset, synchronous, active-high.
- `req_valid` in `N_REQ`: requester i has a word on its data slice.
- `req_data` in `N_REQ*WIDTH`: requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_ready` out `N_REQ`: one-hot or zero; the word from requester i is consumed when `req_valid[i] & req_ready[i]`.
- `fifo_full` in 1: from `fifo`.
- `w_valid` out 1: write strobe to `fifo`.
- `data_in` out `WIDTH`: write data to `fifo`.
- `grant_id` out `$clog2(N_REQ)`: current/last granted requester.
- `busy` out 1: high in `GRANT`.

## Operation
- FSM with two states: `IDLE` and `GRANT`. Registers: `state`, `rr_ptr`, `grant_id`, `beat_cnt` (`$clog2(BURST+1)` bits).
- `IDLE`: search `req_valid` starting at `rr_ptr`, upward, wrapping modulo `N_REQ`. On the first hit, load `grant_id` with it, clear `beat_cnt`, and go to `GRANT`. If there is no hit, stay in `IDLE`. All `req_ready` are 0 and `w_valid` is 0 in `IDLE`.
- `GRANT`, with g = `grant_id`:
  - `req_ready[g] = ~fifo_full`; all other `req_ready` bits are 0.
  - `w_valid = req_valid[g] & ~fifo_full`.
  - `data_in = req_data[g]` (combinational mux).
  - A beat is `w_valid`; each beat increments `beat_cnt`.
- Release `GRANT` → `IDLE` with `rr_ptr <= (g+1) mod N_REQ` when either:
  - (a) a beat occurs and `beat_cnt == BURST-1`, or
  - (b) `req_valid[g]==0` and `fifo_full==0`, i.e. the requester has gone idle.
- While `fifo_full` is high, the grant is held and `beat_cnt` is frozen. A stalled requester therefore never loses its grant to back-pressure, and (b) is evaluated only when not full.
- A requester must hold `req_valid`/`req_data` stable until accepted. The arbiter never drops or duplicates a word.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,N_REQ-1,0,…; each gets exactly `BURST` beats.

## Timing
- Reset (synchronous, `reset` high at a rising edge):
  - `state=IDLE`, `rr_ptr=0`, `grant_id=0`, `beat_cnt=0`.
  - Hence `w_valid=0`, `req_ready=0`, `busy=0`, `data_in` = `req_data[0]`, don't-care.
- Reset mid-burst aborts the grant on that edge. Words already written stay written; no partial state survives.
- Arbitration latency: `req_valid` sampled in `IDLE` at edge n → first possible beat in cycle n+1.
- Each release costs exactly one `IDLE` bubble cycle. Peak throughput is `BURST/(BURST+1)` words/cycle.
- Outputs `w_valid`, `req_ready` and `data_in` are combinational from registered state plus `req_valid`, `req_data` and `fifo_full`. There is no register stage, so `fifo_full` is honoured in the same cycle.
- Simultaneous final beat and `fifo_full` rising next cycle: the release already happened; the next grant sees full and stalls.

## Structure
- Shared package `fifo_pkg` holds:
  - the FSM state typedef (`IDLE`, `GRANT`);
  - the default `WIDTH` constant, shared with `fifo`.
- One natural sub-module, `rr_pick`: combinational priority search of an `N_REQ`-bit vector starting from `rr_ptr`, outputting `hit` and `idx`. It is reusable by a future read-side scheduler.

## Test plan
- Reset then idle:
  - stimulus: `reset` high for 2 cycles, then all `req_valid=0` for 5 cycles;
  - required: `w_valid=0`, `req_ready=0`, `busy=0` throughout.
- Single requester:
  - stimulus: `req_valid[2]=1` continuously with data 0x20..0x29, `BURST=4`, FIFO never full;
  - required: writes 0x20–0x23, one bubble, 0x24–0x27, bubble, …; `grant_id=2` each time.
- Round-robin:
  - stimulus: all four requesters valid with tagged data (0xA0+i for requester 0 at beat i, 0xB0+i for requester 1, …);
  - required: order 0xA0–A3, B0–B3, C0–C3, D0–D3, A4…
- Back-pressure:
  - stimulus: during beat 2 of a grant to requester 1, hold `fifo_full=1` for 3 cycles;
  - required: `req_ready=0`, `w_valid=0`, `beat_cnt` frozen, grant kept; after full drops, the remaining 2 beats complete with no loss or duplicate.
- Early release:
  - stimulus: requester 3 drops `req_valid` after 1 beat while requester 0 is valid;
  - required: release, `rr_ptr=0`, next grant goes to requester 0 after one bubble.
- Reset mid-burst:
  - stimulus: assert `reset` during beat 2;
  - required: next cycle in `IDLE` with `rr_ptr=0`; a scoreboard against the `fifo` contents shows only completed beats.
